image_mem_reader: RTL and testbench
===================================

# image_mem_reader

Streaming read engine that sits directly upstream of the display/processing datapath and drives the read side of the 16-bit image memory: 14-bit word address, one-cycle registered read latency. On a start command it reads `len` consecutive words from `base` and presents them as a valid/ready pixel stream with a last-beat marker. A 4-entry output FIFO absorbs backpressure without losing in-flight reads, and sustains one word per cycle when the consumer is always ready.

## Interface

Parameters:
- `ADDR_W`, 14, memory word-address width.
- `DATA_W`, 16, memory word and pixel width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle command strobe; accepted only in IDLE.
- `base`  in  14  first word address, sampled on accepted `start`.
- `len`  in  15  number of words (0..16384), sampled on accepted `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer completion.
- `mem_enable`  out  1  memory enable.
- `mem_read_enable`  out  1  memory read strobe.
- `mem_write_enable`  out  1  constant 0.
- `mem_address`  out  14  memory word address.
- `mem_data`  in  16  memory read data, valid the cycle after a read is issued.
- `pix_data`  out  16  stream data (FIFO head).
- `pix_valid`  out  1  stream data valid.
- `pix_ready`  in  1  consumer ready.
- `pix_last`  out  1  high with the final word of the transfer.

## Operation

- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: `start`=1 latches `base`/`len`, clears counters. `len`=0 goes to DONE; otherwise goes to READ.
- READ: issues one read per cycle while `fifo_count + inflight < 4`. A read drives `mem_enable`=`mem_read_enable`=1 and `mem_address`=current address. The address then increments modulo 2^14, so 16383 wraps to 0. The FSM goes to DRAIN in the cycle after the `len`-th read is issued.
- `inflight` counts issued reads whose data has not yet been written into the FIFO (0..2).
- Read data returning in cycle t+1 (read issued in cycle t) is written into the FIFO at the end of cycle t+1, unconditionally. The issue rule guarantees the FIFO is never full at that point.
- DRAIN: no reads issued. The FSM goes to DONE on the handshake of the final beat.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- FIFO: 4 entries. Write and pop in the same cycle is allowed; count is unchanged and order is preserved.
- `pix_valid` = FIFO non-empty. A beat transfers when `pix_valid & pix_ready`.
- `pix_last`=1 only while the FIFO head is word number `len` (beat counter = `len`-1).
- `busy`=1 in READ and DRAIN; 0 in IDLE and DONE.
- `start` in READ, DRAIN or DONE is ignored; no queueing.
- Addresses above the populated memory depth are issued unchanged; range checking is the caller's responsibility.
- No write path: `mem_write_enable` is always 0.

## Timing

- Reset (async, `rst_n`=0):
  - state returns to IDLE;
  - FIFO and counters are cleared;
  - `busy`, `done`, `mem_enable`, `mem_read_enable`, `pix_valid` and `pix_last` go to 0;
  - `mem_address` and `pix_data` go to 0.
  These outputs change immediately, without waiting for a clock edge.
- Reset mid-transfer aborts it: no `done` pulse, and data in flight is discarded.
- With `start` in cycle 0:
  - first read issued in cycle 1;
  - `mem_data` valid in cycle 2;
  - `pix_valid`=1 in cycle 3.
- With `pix_ready` held high, beats transfer in consecutive cycles. For `len`=N:
  - last beat in cycle N+2;
  - `done` in cycle N+3;
  - a new `start` is accepted from cycle N+4.
- With `len`=0: `done` in cycle 1, no memory access, no beats.
- Backpressure: issuing stalls within 2 cycles of `pix_ready` going low. The FIFO holds at most 4 words, and no word is dropped or duplicated.
- `pix_data`, `pix_valid` and `pix_last` remain stable while `pix_valid=1 & pix_ready=0`.

## Test plan

- Preload `mem[i]=i+16'hA000`; `base`=10, `len`=5, `pix_ready`=1. Required response:
  - beats A00A..A00E in cycles 3..7;
  - `pix_last` only on A00E;
  - `done` in cycle 8;
  - `busy` high in cycles 1..7.
- Same transfer with `pix_ready` toggling 1,0,0,1,… Required: the same 5 words in order, each output held stable while stalled, FIFO count never above 4, and no read issued while `fifo_count+inflight`=4.
- `base`=16382, `len`=4. Required: reads at addresses 16382, 16383, 0, 1, and data delivered in that order.
- `len`=0. Required: `done` pulse in cycle 1, `pix_valid` and `mem_enable` never asserted.
- `start` pulsed again in cycle 2 with different `base`/`len`. Required: the command is ignored and the original transfer completes unchanged.
- `rst_n` pulsed low during beat 3 of `len`=8. Required: all outputs drop to 0 without a clock edge, no `done` pulse, and a following `start` runs a clean transfer from its own `base`.

Source files
------------

// File: rtl/image_mem_reader_if.sv
// Bundles the command, image-memory read port and pixel stream signals of image_mem_reader.
//   start/base/len   : transfer command (sampled when the reader is idle)
//   busy/done        : transfer status
//   mem_*            : read side of the 16-bit image memory (1-cycle registered latency)
//   pix_*            : valid/ready pixel stream with last-beat marker
// Modports: master = the reader, slave = its environment.
interface image_mem_reader_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              mem_enable;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_last;

    modport master (
        input  start, base, len, mem_data, pix_ready,
        output busy, done, mem_enable, mem_read_enable, mem_write_enable,
               mem_address, pix_data, pix_valid, pix_last
    );

    modport slave (
        output start, base, len, mem_data, pix_ready,
        input  busy, done, mem_enable, mem_read_enable, mem_write_enable,
               mem_address, pix_data, pix_valid, pix_last
    );
endinterface

// File: rtl/image_mem_reader.sv
// Streaming read engine: on start, reads len consecutive words from base out of the
// image memory and presents them as a valid/ready pixel stream, with a 4-entry FIFO
// absorbing backpressure.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : image_mem_reader_if.master (command, status, memory read port, pixel stream)
module image_mem_reader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    image_mem_reader_if.master bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              rd_q, rd_d;              // read issued in the current cycle
    logic              inflight_q, inflight_d;  // read issued last cycle; its data is on mem_data
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] fifo_q [DEPTH];
    logic [DATA_W-1:0] fifo_d [DEPTH];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              pop_c;
    logic [CNT_W-1:0]  kept_c;

    // Next-state, FIFO and registered-output computation
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = rd_q;
        fifo_d     = fifo_q;

        // Shift FIFO: entry 0 is always the head, so pix_data comes straight from a flop
        pop_c  = valid_q & bus.pix_ready;
        kept_c = count_q - CNT_W'(pop_c);
        if (pop_c) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                fifo_d[i] = fifo_q[i + 1];
            end
            beat_d = beat_q + LEN_W'(1);
        end
        // Returning read data lands right behind whatever survives this cycle's pop
        if (inflight_q) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CNT_W'(i) == kept_c) begin
                    fifo_d[i] = bus.mem_data;
                end
            end
        end
        count_d = kept_c + CNT_W'(inflight_q);

        if (rd_q) begin
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d   = bus.base;
                    len_d    = bus.len;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = (bus.len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (rd_q && (issued_d == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop_c && (beat_q == len_q - LEN_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Issue next cycle only if every word in FIFO or in flight still has a slot
        rd_d    = (state_d == ST_READ) && ((count_d + CNT_W'(inflight_d)) < CNT_W'(DEPTH));
        busy_d  = (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        valid_d = (count_d != '0);
        last_d  = valid_d && ((beat_d + LEN_W'(1)) == len_d);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            rd_q       <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            rd_q       <= rd_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.mem_enable       = rd_q;
    assign bus.mem_read_enable  = rd_q;
    assign bus.mem_write_enable = 1'b0;
    assign bus.mem_address      = addr_q;
    assign bus.pix_data         = fifo_q[0];
    assign bus.pix_valid        = valid_q;
    assign bus.pix_last         = last_q;
endmodule

// File: tb/tb_image_mem_reader.sv
// Self-checking bench for image_mem_reader: a synchronous memory model feeds the reader,
// and a queue-based reference (expected word list + cycle targets) checks the stream.
module tb_image_mem_reader;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_WORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    image_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Image memory: one-cycle registered read
    logic [DATA_W-1:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_read_enable) begin
            bus.mem_data <= mem[bus.mem_address];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state for the current transfer
    logic [DATA_W-1:0] exp_q [$];
    int exp_base, exp_len, c0;
    int n_rd, n_pop, n_done, n_valid;
    int first_valid_cyc, last_cyc, done_cyc;
    bit mon_en = 1'b0;
    bit stalled = 1'b0;
    bit ready_high = 1'b0;
    int rdy_mode = 0;
    logic [DATA_W-1:0] held_data;
    logic held_last;

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.pix_ready = (((cyc - c0) % 3) == 0);
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b1;
            endcase
        end
    end

    // Monitor: sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (bus.mem_enable) begin
                check("mem_read_enable", 32'(bus.mem_read_enable), 32'd1);
                check("mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
                check("rd_addr", 32'(bus.mem_address), 32'((exp_base + n_rd) % MEM_WORDS));
                check("room_at_issue", 32'((n_rd - n_pop) < 4), 32'd1);
                n_rd++;
            end
            if (bus.pix_valid) begin
                n_valid++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stalled) begin
                    check("hold_data", 32'(bus.pix_data), 32'(held_data));
                    check("hold_last", 32'(bus.pix_last), 32'(held_last));
                end
                if (bus.pix_ready) begin
                    if (n_pop < exp_q.size())
                        check("pix_data", 32'(bus.pix_data), 32'(exp_q[n_pop]));
                    else
                        check("extra_beat", 32'(n_pop), 32'(exp_q.size()));
                    check("pix_last", 32'(bus.pix_last), 32'(n_pop == exp_len - 1));
                    last_cyc = cyc;
                    n_pop++;
                end
                held_data = bus.pix_data;
                held_last = bus.pix_last;
                stalled   = !bus.pix_ready;
            end else begin
                stalled = 1'b0;
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (ready_high) begin
                check("busy", 32'(bus.busy),
                      32'((exp_len > 0) && (cyc >= c0 + 1) && (cyc <= c0 + exp_len + 2)));
            end
        end
    end

    task automatic arm(input int b, input int n, input int mode);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % MEM_WORDS]);
        exp_base = b;
        exp_len = n;
        n_rd = 0;
        n_pop = 0;
        n_done = 0;
        n_valid = 0;
        first_valid_cyc = -1;
        last_cyc = -1;
        done_cyc = -1;
        stalled = 1'b0;
        rdy_mode = mode;
        ready_high = (mode == 0);
    endtask

    task automatic issue_start(input int b, input int n);
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.start = 1'b1;
        bus.base = ADDR_W'(b);
        bus.len = (ADDR_W + 1)'(n);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_xfer(input int b, input int n, input int mode, input bit restart);
        arm(b, n, mode);
        issue_start(b, n);
        if (restart) begin
            @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.base = ADDR_W'(b + 500);
            bus.len = (ADDR_W + 1)'(3);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        for (int k = 0; k < 100 + 20 * n && n_done == 0; k++) @(posedge clk);
        repeat (2) @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("done_count", 32'(n_done), 32'd1);
        check("beats", 32'(n_pop), 32'(n));
        check("reads", 32'(n_rd), 32'(n));
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        if (n == 0) check("len0_no_valid", 32'(n_valid), 32'd0);
        if (ready_high) begin
            check("done_cycle", 32'(done_cyc - c0), 32'((n == 0) ? 1 : n + 3));
            if (n > 0) begin
                check("first_valid_cycle", 32'(first_valid_cyc - c0), 32'd3);
                check("last_beat_cycle", 32'(last_cyc - c0), 32'(n + 2));
            end
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_busy"}, 32'(bus.busy), 32'd0);
        check({pfx, "_done"}, 32'(bus.done), 32'd0);
        check({pfx, "_mem_enable"}, 32'(bus.mem_enable), 32'd0);
        check({pfx, "_mem_read_enable"}, 32'(bus.mem_read_enable), 32'd0);
        check({pfx, "_mem_address"}, 32'(bus.mem_address), 32'd0);
        check({pfx, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        check({pfx, "_pix_last"}, 32'(bus.pix_last), 32'd0);
        check({pfx, "_pix_data"}, 32'(bus.pix_data), 32'd0);
    endtask

    // Abort an 8-word transfer with an asynchronous reset while beat 3 is presented
    task automatic reset_mid();
        arm(100, 8, 0);
        issue_start(100, 8);
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(bus.pix_valid), 32'd1);
        check("pre_rst_beat3", 32'(bus.pix_data), 32'(exp_q[2]));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        arm(100, 0, 0);
        ready_high = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("post_rst_no_done", 32'(n_done), 32'd0);
        check("post_rst_no_valid", 32'(n_valid), 32'd0);
        check("post_rst_no_reads", 32'(n_rd), 32'd0);
        run_xfer(300, 6, 0, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base = '0;
        bus.len = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = DATA_W'(i + 16'hA000);
        repeat (3) @(posedge clk);
        #3;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_xfer(10, 5, 0, 1'b0);
        run_xfer(10, 5, 1, 1'b0);
        run_xfer(16382, 4, 0, 1'b0);
        run_xfer(0, 0, 0, 1'b0);
        run_xfer(10, 5, 0, 1'b1);
        reset_mid();

        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = DATA_W'($urandom);
        for (int t = 0; t < 12; t++) begin
            int b;
            b = (t % 4 == 0) ? int'($urandom_range(MEM_WORDS - 8, MEM_WORDS - 1))
                             : int'($urandom_range(0, MEM_WORDS - 1));
            run_xfer(b, int'($urandom_range(1, 24)), int'($urandom_range(0, 2)), 1'b0);
        end
        run_xfer(int'($urandom_range(0, MEM_WORDS - 1)), 1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
